// File: rtl/mult_pkg.sv
// Shared widths and a constant-evaluable log2 helper for the multiplier arbiter.
package mult_pkg;

  localparam int OPERAND_W = 64;
  localparam int PRODUCT_W = 128;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mult_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each operation inside the multiplier.
module mult_tag_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count,
  output logic [W-1:0]            head
);

  localparam int PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/mult_128_arbiter.sv
// Round-robin arbiter sharing one pipelined 64x64->128 multiplier between requesters;
// an in-order tag FIFO routes each product back to the requester that issued it.
module mult_128_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_a_tdata,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_b_tdata,
  input  logic [NUM_REQ-1:0]             req_tvalid,
  output logic [NUM_REQ-1:0]             req_tready,
  output logic [PRODUCT_W-1:0]           rsp_tdata,
  output logic [NUM_REQ-1:0]             rsp_tvalid,
  input  logic [NUM_REQ-1:0]             rsp_tready,
  output logic [OPERAND_W-1:0]           m_a_tdata,
  output logic [OPERAND_W-1:0]           m_b_tdata,
  output logic                           m_a_tvalid,
  output logic                           m_b_tvalid,
  input  logic                           m_a_tready,
  input  logic                           m_b_tready,
  input  logic [PRODUCT_W-1:0]           m_out_tdata,
  input  logic                           m_out_tvalid,
  output logic                           m_out_tready,
  output logic                           busy,
  output logic                           err_orphan
);

  localparam int ID_W = clog2(NUM_REQ);
  localparam int CW   = clog2(MAX_INFLIGHT) + 1;

  logic                 issue_valid_q, issue_valid_d;
  logic [OPERAND_W-1:0] issue_a_q, issue_a_d;
  logic [OPERAND_W-1:0] issue_b_q, issue_b_d;
  logic [ID_W-1:0]      issue_tag_q, issue_tag_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic                 err_orphan_q, err_orphan_d;

  logic                 fire, slot_free, grant_valid, any_req;
  logic [ID_W-1:0]      grant_idx;
  logic [CW:0]          occupancy;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]        fifo_count;
  logic [ID_W-1:0]      head_tag;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!any_req && req_tvalid[cand_idx]) begin
        any_req   = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // The operation parked in the issue register already owns a FIFO slot, so a
  // later fire can never push into a full tag FIFO.
  always_comb begin
    fire        = issue_valid_q & m_a_tready & m_b_tready;
    occupancy   = {1'b0, fifo_count} + (CW + 1)'(issue_valid_q);
    slot_free   = (~issue_valid_q | fire) & ~fifo_full &
                  (occupancy < (CW + 1)'(MAX_INFLIGHT));
    grant_valid = slot_free & any_req & ~rst;

    req_tready    = '0;
    issue_valid_d = issue_valid_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    issue_tag_d   = issue_tag_q;
    rr_d          = rr_q;
    if (grant_valid) begin
      req_tready[grant_idx] = 1'b1;
      issue_valid_d = 1'b1;
      issue_a_d     = req_a_tdata[grant_idx*OPERAND_W +: OPERAND_W];
      issue_b_d     = req_b_tdata[grant_idx*OPERAND_W +: OPERAND_W];
      issue_tag_d   = grant_idx;
      rr_d          = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (fire) begin
      issue_valid_d = 1'b0;
    end

    rsp_tvalid = '0;
    if (m_out_tvalid && !fifo_empty) rsp_tvalid[head_tag] = 1'b1;
    m_out_tready = fifo_empty | rsp_tready[head_tag];
    fifo_pop     = m_out_tvalid & ~fifo_empty & rsp_tready[head_tag];
    err_orphan_d = err_orphan_q | (m_out_tvalid & fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      issue_tag_q   <= '0;
      rr_q          <= '0;
      err_orphan_q  <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
      issue_tag_q   <= issue_tag_d;
      rr_q          <= rr_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  mult_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (issue_tag_q),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_tag)
  );

  assign m_a_tdata  = issue_a_q;
  assign m_b_tdata  = issue_b_q;
  assign m_a_tvalid = issue_valid_q;
  assign m_b_tvalid = issue_valid_q;
  assign rsp_tdata  = m_out_tdata;
  assign busy       = issue_valid_q | ~fifo_empty;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_mult_128_arbiter.sv
// Directed bench for mult_128_arbiter with a behavioural in-order multiplier (latency 2).
module tb_mult_128_arbiter;

  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*64-1:0]  req_a_tdata, req_b_tdata;
  logic [NR-1:0]     req_tvalid, req_tready;
  logic [127:0]      rsp_tdata;
  logic [NR-1:0]     rsp_tvalid, rsp_tready;
  logic [63:0]       m_a_tdata, m_b_tdata;
  logic              m_a_tvalid, m_b_tvalid, m_a_tready, m_b_tready;
  logic [127:0]      m_out_tdata;
  logic              m_out_tvalid, m_out_tready, busy, err_orphan;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic          mul_hold = 1'b0;
  logic          inject_v = 1'b0;
  logic [127:0]  inject_d = '0;

  int            rem [NR];
  logic [63:0]   op_a [NR];
  logic [63:0]   op_b [NR];
  bit            grant_flag [NR];

  int            g_idx[$];
  int            g_cyc[$];
  logic [127:0]  g_prod[$];
  int            r_idx[$];
  logic [NR-1:0] r_vec[$];
  logic [127:0]  r_data[$];

  always #5 clk = ~clk;

  mult_128_arbiter #(.NUM_REQ(NR), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .req_a_tdata(req_a_tdata), .req_b_tdata(req_b_tdata),
    .req_tvalid(req_tvalid), .req_tready(req_tready),
    .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .m_a_tdata(m_a_tdata), .m_b_tdata(m_b_tdata),
    .m_a_tvalid(m_a_tvalid), .m_b_tvalid(m_b_tvalid),
    .m_a_tready(m_a_tready), .m_b_tready(m_b_tready),
    .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
    .busy(busy), .err_orphan(err_orphan)
  );

  function automatic logic [127:0] mul64(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  // Multiplier model: unbounded in-order queue, accepts whenever not held.
  typedef struct { logic [127:0] p; int rdy; } mop_t;
  mop_t         mq[$];
  int           mcyc = 0;
  logic         mv = 1'b0;
  logic [127:0] md = '0;

  assign m_a_tready   = ~mul_hold;
  assign m_b_tready   = ~mul_hold;
  assign m_out_tvalid = mv | inject_v;
  assign m_out_tdata  = inject_v ? inject_d : md;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcyc = 0;
      mv <= 1'b0;
      md <= '0;
    end else begin
      mop_t op;
      mcyc = mcyc + 1;
      if (mv && m_out_tready) void'(mq.pop_front());
      if (m_a_tvalid && m_a_tready && m_b_tready) begin
        op.p = mul64(m_a_tdata, m_b_tdata);
        op.rdy = mcyc + 1;
        mq.push_back(op);
      end
      if (mq.size() > 0 && mq[0].rdy <= mcyc) begin
        mv <= 1'b1;
        md <= mq[0].p;
      end else begin
        mv <= 1'b0;
      end
    end
  end

  // Monitor: handshakes sampled mid-cycle, they complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (req_tready[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
          g_prod.push_back(mul64(req_a_tdata[64*i +: 64], req_b_tdata[64*i +: 64]));
          grant_flag[i] = 1'b1;
        end
      end
      if ((rsp_tvalid & rsp_tready) != '0) begin
        int who;
        who = -1;
        for (int i = NR - 1; i >= 0; i--) if (rsp_tvalid[i] && rsp_tready[i]) who = i;
        r_idx.push_back(who);
        r_vec.push_back(rsp_tvalid);
        r_data.push_back(rsp_tdata);
      end
    end
  end

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (grant_flag[i]) begin
        grant_flag[i] = 1'b0;
        rem[i]--;
        op_a[i] = op_a[i] + 64'd1;
        op_b[i] = op_b[i] + 64'd3;
      end
      req_tvalid[i] = (rem[i] > 0);
      req_a_tdata[64*i +: 64] = op_a[i];
      req_b_tdata[64*i +: 64] = op_b[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_reqs();
  endtask

  task automatic clear_logs();
    g_idx.delete(); g_cyc.delete(); g_prod.delete();
    r_idx.delete(); r_vec.delete(); r_data.delete();
    for (int i = 0; i < NR; i++) grant_flag[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mul_hold = 1'b0; inject_v = 1'b0; inject_d = '0; rsp_tready = '1;
    req_tvalid = '0; req_a_tdata = '0; req_b_tdata = '0;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; op_a[i] = '0; op_b[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (req_tready !== 4'b0) begin errors++; $display("FAIL reset_req_tready got %b expected 0000", req_tready); end
    checks++; if (rsp_tvalid !== 4'b0) begin errors++; $display("FAIL reset_rsp_tvalid got %b expected 0000", rsp_tvalid); end
    checks++; if ({m_a_tvalid, m_b_tvalid} !== 2'b00) begin errors++; $display("FAIL reset_m_tvalid got %b expected 00", {m_a_tvalid, m_b_tvalid}); end
    checks++; if ({busy, err_orphan} !== 2'b00) begin errors++; $display("FAIL reset_busy_err got %b expected 00", {busy, err_orphan}); end
    // Two ops in flight, then reset asynchronously mid-cycle.
    @(posedge clk); #1;
    rem[0] = 1; rem[1] = 1;
    op_a[0] = 64'd5; op_b[0] = 64'd6; op_a[1] = 64'd7; op_b[1] = 64'd8;
    drive_reqs();
    repeat (3) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b expected 1", busy); end
    checks++; if (g_idx.size() != 2) begin errors++; $display("FAIL midop_grants got %0d expected 2", g_idx.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({m_a_tvalid, busy} !== 2'b00) begin errors++; $display("FAIL async_valid_busy got %b expected 00", {m_a_tvalid, busy}); end
    checks++; if ({req_tready, rsp_tvalid} !== 8'h00) begin errors++; $display("FAIL async_ready_valid got %h expected 00", {req_tready, rsp_tvalid}); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (6) tick();
    @(negedge clk);
    checks++; if (r_idx.size() != 0) begin errors++; $display("FAIL midop_lost got %0d responses expected 0", r_idx.size()); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL midop_orphan got %b expected 0", err_orphan); end
  endtask

  task automatic test_single();
    int t;
    do_reset();
    rem[1] = 1; op_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; op_b[1] = 64'd2;
    drive_reqs();
    @(negedge clk);
    checks++; if (req_tready !== 4'b0010) begin errors++; $display("FAIL single_grant got %b expected 0010", req_tready); end
    tick();
    @(negedge clk);
    checks++; if (m_a_tvalid !== 1'b1) begin errors++; $display("FAIL single_latency got %b expected 1", m_a_tvalid); end
    checks++; if ({m_a_tdata, m_b_tdata} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'd2}) begin errors++; $display("FAIL single_operands got %h %h expected ffffffffffffffff 2", m_a_tdata, m_b_tdata); end
    t = 0;
    while (r_idx.size() < 1 && t < 30) begin tick(); t++; end
    checks++;
    if (r_idx.size() < 1) begin
      errors++; $display("FAIL single_timeout got 0 responses expected 1");
    end else begin
      checks++; if (r_vec[0] !== 4'b0010) begin errors++; $display("FAIL single_rsp_tvalid got %b expected 0010", r_vec[0]); end
      checks++; if (r_data[0] !== 128'h1_FFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL single_product got %h expected 1fffffffffffffffe", r_data[0]); end
    end
    repeat (3) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int t;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 2;
      op_a[i] = 64'hDEAD_0000 + 64'(i);
      op_b[i] = 64'h1_0000 + 64'(16 * i);
    end
    drive_reqs();
    t = 0;
    while (r_idx.size() < 8 && t < 80) begin tick(); t++; end
    checks++;
    if (r_idx.size() < 8 || g_idx.size() < 8) begin
      errors++; $display("FAIL rr_timeout got %0d responses %0d grants expected 8", r_idx.size(), g_idx.size());
    end else begin
      checks++; if (g_cyc[4] - g_cyc[0] != 4) begin errors++; $display("FAIL rr_back_to_back got span %0d expected 4", g_cyc[4] - g_cyc[0]); end
      for (int k = 0; k < 8; k++) begin
        checks++; if (g_idx[k] != exp_g[k]) begin errors++; $display("FAIL rr_grant_%0d got %0d expected %0d", k, g_idx[k], exp_g[k]); end
        checks++; if (r_idx[k] != exp_g[k]) begin errors++; $display("FAIL rr_owner_%0d got %0d expected %0d", k, r_idx[k], exp_g[k]); end
        checks++; if (r_data[k] !== g_prod[k]) begin errors++; $display("FAIL rr_data_%0d got %h expected %h", k, r_data[k], g_prod[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    rsp_tready = 4'b1110;
    rem[0] = 6; op_a[0] = 64'h0123_4567_89AB_CDEF; op_b[0] = 64'h10;
    drive_reqs();
    repeat (6) tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (req_tready !== 4'b0) begin errors++; $display("FAIL full_no_grant_%0d got %b expected 0000", c, req_tready); end
      checks++; if (m_out_tready !== 1'b0) begin errors++; $display("FAIL full_m_out_tready_%0d got %b expected 0", c, m_out_tready); end
      tick();
    end
    checks++; if (g_idx.size() != 4) begin errors++; $display("FAIL full_inflight got %0d expected 4", g_idx.size()); end
    checks++; if (r_idx.size() != 0) begin errors++; $display("FAIL full_no_rsp got %0d expected 0", r_idx.size()); end
    rsp_tready = '1;
    t = 0;
    while (r_idx.size() < 6 && t < 60) begin tick(); t++; end
    checks++;
    if (r_idx.size() < 6 || g_prod.size() < 6) begin
      errors++; $display("FAIL drain_timeout got %0d responses expected 6", r_idx.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (r_idx[k] != 0) begin errors++; $display("FAIL drain_owner_%0d got %0d expected 0", k, r_idx[k]); end
        checks++; if (r_data[k] !== g_prod[k]) begin errors++; $display("FAIL drain_data_%0d got %h expected %h", k, r_data[k], g_prod[k]); end
      end
    end
  endtask

  task automatic test_issue_stall();
    int exp_r [3] = '{2, 3, 2};
    int t;
    do_reset();
    mul_hold = 1'b1;
    rem[2] = 2; op_a[2] = 64'hAAAA_5555_AAAA_5555; op_b[2] = 64'd3;
    rem[3] = 1; op_a[3] = 64'd7; op_b[3] = 64'd9;
    drive_reqs();
    @(negedge clk);
    checks++; if (req_tready !== 4'b0100) begin errors++; $display("FAIL stall_first_grant got %b expected 0100", req_tready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (m_a_tvalid !== 1'b1 || m_a_tdata !== 64'hAAAA_5555_AAAA_5555) begin errors++; $display("FAIL stall_hold_%0d got %b %h expected 1 aaaa5555aaaa5555", c, m_a_tvalid, m_a_tdata); end
      checks++; if (req_tready !== 4'b0) begin errors++; $display("FAIL stall_no_grant_%0d got %b expected 0000", c, req_tready); end
      tick();
    end
    mul_hold = 1'b0;
    t = 0;
    while (r_idx.size() < 3 && t < 40) begin tick(); t++; end
    checks++;
    if (r_idx.size() < 3 || g_prod.size() < 3) begin
      errors++; $display("FAIL stall_timeout got %0d responses expected 3", r_idx.size());
    end else begin
      checks++; if (r_data[1] !== 128'd63) begin errors++; $display("FAIL stall_req3_product got %h expected 3f", r_data[1]); end
      for (int k = 0; k < 3; k++) begin
        checks++; if (r_idx[k] != exp_r[k]) begin errors++; $display("FAIL stall_owner_%0d got %0d expected %0d", k, r_idx[k], exp_r[k]); end
        checks++; if (r_data[k] !== g_prod[k]) begin errors++; $display("FAIL stall_data_%0d got %h expected %h", k, r_data[k], g_prod[k]); end
      end
    end
  endtask

  task automatic test_orphan();
    do_reset();
    inject_v = 1'b1; inject_d = 128'h1234;
    @(negedge clk);
    checks++; if ({rsp_tvalid, m_out_tready, err_orphan} !== 6'b0000_10) begin errors++; $display("FAIL orphan_before got %b expected 000010", {rsp_tvalid, m_out_tready, err_orphan}); end
    tick();
    inject_v = 1'b0;
    @(negedge clk);
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag got %b expected 1", err_orphan); end
    checks++; if ({rsp_tvalid, busy} !== 5'b0) begin errors++; $display("FAIL orphan_no_rsp got %b expected 00000", {rsp_tvalid, busy}); end
    repeat (3) tick();
    @(negedge clk);
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b expected 1", err_orphan); end
    checks++; if (r_idx.size() != 0) begin errors++; $display("FAIL orphan_delivered got %0d expected 0", r_idx.size()); end
    do_reset();
    @(negedge clk);
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_cleared got %b expected 0", err_orphan); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_issue_stall();
    test_orphan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
